// File: rtl/spi_slave_pkg.sv
// Shared types and frame-layout constants for the SPI slave register file.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA,
        DONE
    } state_e;

    localparam int HDR_BITS = 8;
    localparam int WR_BIT   = 7;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronised level.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    // Resetting to 0 means a chip select held low across reset produces no
    // fall, so the link only re-arms on a genuine cs fall afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the previous
            // stage's old value, which is what makes this a shift chain.
            sync_q <= {sync_q[STAGES-2:0], d_i};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = q_o & ~dly_q;
    assign fall_o = ~q_o & dly_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave exposing NUM_RD status words and NUM_WR control registers.
// Define SPI_SLAVE_BURST_EN to allow several auto-incrementing words per frame.
module spi_slave_regfile
    import spi_slave_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter int NUM_RD      = 16,
    parameter int NUM_WR      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     spi_clk,
    input  logic                     spi_cs_n,
    input  logic                     spi_mosi,
    output logic                     spi_miso,
    input  logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [NUM_WR-1:0]        wr_strobe,
    output logic                     frame_err
);

    localparam int              CNT_W     = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_BITS - 1);
    localparam logic [CNT_W-1:0] HDR_END   = CNT_W'(HDR_BITS);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);

    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic cs_rise, cs_fall, cs_lvl_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .d_i(spi_clk),
        .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .reset_n(reset_n), .d_i(spi_cs_n),
        .q_o(cs_lvl_unused), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .d_i(spi_mosi),
        .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic                pend_q, pend_d;
    logic                miso_q, miso_d;
    logic                err_q, err_d;
    logic                commit;
    logic [DATA_W-1:0]   rx_word;
    logic [DATA_W-1:0]   rd_sel;
    logic                addr_in_wr;
    logic [NUM_WR-1:0]   strobe_d, strobe_q;
    logic [NUM_WR*DATA_W-1:0] wr_data_q;

    // Out-of-range reads return zero; this is the snapshot taken at load time.
    always_comb begin
        rd_sel     = '0;
        addr_in_wr = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (int'(addr_q) == i) rd_sel = rd_data[i*DATA_W +: DATA_W];
        end
        for (int i = 0; i < NUM_WR; i++) begin
            if (int'(addr_q) == i) addr_in_wr = 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        pend_d  = pend_q;
        miso_d  = miso_q;
        err_d   = 1'b0;
        commit  = 1'b0;
        rx_word = {rx_q[DATA_W-2:0], mosi_s};

        unique case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d = HEADER;
                    cnt_d   = '0;
                    rx_d    = '0;
                    tx_d    = '0;
                    pend_d  = 1'b0;
                end
            end
            HEADER: begin
                if (cs_rise) begin
                    err_d   = pend_q;
                    state_d = IDLE;
                    miso_d  = 1'b0;
                end else if (sclk_rise && cnt_q != HDR_END) begin
                    rx_d   = rx_word;
                    cnt_d  = cnt_q + CNT_W'(1);
                    pend_d = 1'b1;
                    if (cnt_q == HDR_LAST) begin
                        addr_d = rx_word[ADDR_W-1:0];
                        wr_d   = rx_word[WR_BIT];
                    end
                end else if (sclk_fall && cnt_q == HDR_END) begin
                    miso_d  = rd_sel[DATA_W-1];
                    tx_d    = {rd_sel[DATA_W-2:0], 1'b0};
                    rx_d    = '0;
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cs_rise) begin
                    err_d   = pend_q;
                    state_d = IDLE;
                    miso_d  = 1'b0;
                end else if (sclk_rise) begin
                    rx_d   = rx_word;
                    pend_d = 1'b1;
                    if (cnt_q == WORD_LAST) begin
                        commit = wr_q && addr_in_wr;
                        pend_d = 1'b0;
                        cnt_d  = '0;
`ifdef SPI_SLAVE_BURST_EN
                        addr_d = addr_q + ADDR_W'(1);
`else
                        state_d = DONE;
                        miso_d  = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    // A fall at bit 0 only occurs between burst words: reload.
                    if (cnt_q == '0) begin
                        miso_d = rd_sel[DATA_W-1];
                        tx_d   = {rd_sel[DATA_W-2:0], 1'b0};
                    end else begin
                        miso_d = tx_q[DATA_W-1];
                        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            DONE: begin
                miso_d = 1'b0;
                if (cs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        strobe_d = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (commit && int'(addr_q) == i) strobe_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            pend_q  <= 1'b0;
            miso_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            pend_q  <= pend_d;
            miso_q  <= miso_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the control registers are plain flops driving live outputs, so
    // they are reset; a RAM-style array would normally be left unreset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_data_q <= '0;
            strobe_q  <= '0;
        end else begin
            strobe_q <= strobe_d;
            for (int i = 0; i < NUM_WR; i++) begin
                if (strobe_d[i]) wr_data_q[i*DATA_W +: DATA_W] <= rx_word;
            end
        end
    end

    assign spi_miso  = miso_q;
    assign wr_data   = wr_data_q;
    assign wr_strobe = strobe_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Scoreboard bench: bit-banged SPI master, reference register model, and
// independent monitors for MISO words, write strobes and frame errors.
module tb_spi_slave_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NUM_RD = 8;
    localparam int NUM_WR = 8;
    localparam int HDR    = 8;
    localparam int CW     = NUM_WR * DATA_W;
    localparam int H      = 60;
`ifdef SPI_SLAVE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef struct {
        int                idx;
        logic [DATA_W-1:0] data;
    } wr_exp_t;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     spi_clk, spi_cs_n, spi_mosi, spi_miso;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [CW-1:0]            wr_data;
    logic [NUM_WR-1:0]        wr_strobe;
    logic                     frame_err;

    logic [DATA_W-1:0] rd_mem [NUM_RD];
    logic [DATA_W-1:0] wr_mem [NUM_WR];
    logic [DATA_W-1:0] exp_rd [$];
    wr_exp_t           exp_wr [$];
    logic [DATA_W-1:0] stim   [$];
    int                exp_err = 0;
    int                n_tests = 0;
    int                n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) rd_data[i*DATA_W +: DATA_W] = rd_mem[i];
    end

    spi_slave_regfile #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
        .NUM_WR(NUM_WR), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .rd_data(rd_data),
        .wr_data(wr_data), .wr_strobe(wr_strobe), .frame_err(frame_err)
    );

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] model_bus();
        logic [CW-1:0] b;
        for (int i = 0; i < NUM_WR; i++) b[i*DATA_W +: DATA_W] = wr_mem[i];
        return b;
    endfunction

    // MISO monitor: header bits must be zero, each complete word is scored.
    int                mon_bits = 0;
    logic              hdr_or;
    logic [DATA_W-1:0] mon_word;
    always @(posedge spi_clk or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            mon_bits = 0;
        end else begin
            if (mon_bits < HDR) begin
                hdr_or = (mon_bits == 0) ? spi_miso : (hdr_or | spi_miso);
                if (mon_bits == HDR - 1) check("hdr_miso_zero", CW'(hdr_or), '0);
            end else begin
                mon_word = {mon_word[DATA_W-2:0], spi_miso};
                if ((mon_bits - HDR) % DATA_W == DATA_W - 1) begin
                    check("rd_word_expected", CW'(exp_rd.size() > 0), CW'(1));
                    if (exp_rd.size() > 0) check("rd_word", CW'(mon_word), CW'(exp_rd.pop_front()));
                end
            end
            mon_bits++;
        end
    end

    // Write-strobe and frame-error monitor.
    always @(negedge clk) begin
        if (reset_n) begin
            if (wr_strobe != '0) begin
                check("strobe_expected", CW'(exp_wr.size() > 0), CW'(1));
                if (exp_wr.size() > 0) begin
                    wr_exp_t           e;
                    logic [NUM_WR-1:0] s;
                    e = exp_wr.pop_front();
                    s = '0;
                    s[e.idx] = 1'b1;
                    check("wr_strobe", CW'(wr_strobe), CW'(s));
                    check("wr_data_word", CW'(wr_data[e.idx*DATA_W +: DATA_W]), CW'(e.data));
                end
            end
            if (frame_err) begin
                check("frame_err_expected", CW'(exp_err > 0), CW'(1));
                if (exp_err > 0) exp_err--;
            end
        end
    end

    task automatic send_bit(input logic b);
        spi_mosi = b;
        #H spi_clk = 1'b1;
        #H spi_clk = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_miso", CW'(spi_miso), '0);
        check("rst_wr_data", wr_data, '0);
        check("rst_strobe", CW'(wr_strobe), '0);
        reset_n = 1'b1;
        for (int i = 0; i < NUM_WR; i++) wr_mem[i] = '0;
    endtask

    // One frame: header, nwords full payload words, partial trailing bits,
    // optional reset after rst_at trailing bits.
    task automatic frame(input logic [7:0] hdr, input int nwords, input int partial, input int rst_at);
        int                a, ak, sent;
        bit                wr;
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] words [$];
        a  = int'(hdr[ADDR_W-1:0]);
        wr = hdr[7];
        for (int k = 0; k < nwords; k++) begin
            w = (k < stim.size()) ? stim[k] : DATA_W'($urandom);
            words.push_back(w);
            if (BURST || k == 0) begin
                ak = BURST ? (a + k) % (1 << ADDR_W) : a;
                exp_rd.push_back(ak < NUM_RD ? rd_mem[ak] : '0);
                if (wr && ak < NUM_WR) begin
                    exp_wr.push_back('{ak, w});
                    wr_mem[ak] = w;
                end
            end else begin
                exp_rd.push_back('0);
            end
        end
        if (rst_at < 0 && partial > 0 && (BURST || nwords == 0)) exp_err++;
        stim.delete();

        spi_cs_n = 1'b0;
        #H;
        for (int i = 7; i >= 0; i--) send_bit(hdr[i]);
        sent = 0;
        for (int k = 0; k < nwords; k++) begin
            for (int i = DATA_W - 1; i >= 0; i--) begin
                send_bit(words[k][i]);
                sent++;
                // Source changes after the load must not affect this frame.
                if (sent == 1 && a < NUM_RD) rd_mem[a] = DATA_W'($urandom);
            end
        end
        for (int p = 0; p < partial; p++) begin
            send_bit(1'($urandom));
            if (p + 1 == rst_at) do_reset();
        end
        #H spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #(4 * H);
        check("drain_rd", CW'(exp_rd.size()), '0);
        check("drain_wr", CW'(exp_wr.size()), '0);
        check("drain_err", CW'(exp_err), '0);
        check("wr_bus", wr_data, model_bus());
    endtask

    initial begin
        #(600_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hdr;
        int         nw, pt;
        reset_n  = 1'b0;
        spi_clk  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        for (int i = 0; i < NUM_RD; i++) rd_mem[i] = DATA_W'($urandom);
        for (int i = 0; i < NUM_WR; i++) wr_mem[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_miso", CW'(spi_miso), '0);
        check("reset_wr_data", wr_data, '0);
        check("reset_strobe", CW'(wr_strobe), '0);
        check("reset_frame_err", CW'(frame_err), '0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        rd_mem[3] = 32'hDEADBEEF;
        frame(8'h03, 1, 0, -1);
        stim.push_back(32'h12345678);
        frame(8'h87, 1, 0, -1);
        frame(8'h85, 0, 20, -1);
        frame(8'h05, 1, 0, -1);
        frame(8'h8A, 1, 0, -1);
        frame(8'h0A, 1, 0, -1);
        frame(8'h81, 0, 20, 10);
        frame(8'h00, 1, 0, -1);
        stim.push_back(32'hA5A5_0001);
        stim.push_back(32'hB6B6_0002);
        stim.push_back(32'hC7C7_0003);
        frame(8'h8F, 3, 0, -1);
        frame(8'h82, 1, 12, -1);

        for (int r = 0; r < 16; r++) begin
            hdr = {1'($urandom), 3'b000, 4'($urandom)};
            nw  = $urandom_range(0, 3);
            pt  = (nw == 0 || $urandom_range(0, 1) == 1) ? $urandom_range(1, DATA_W - 1) : 0;
            rd_mem[$urandom_range(0, NUM_RD - 1)] = DATA_W'($urandom);
            frame(hdr, nw, pt, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
